// File: rtl/distributor.sv
`default_nettype none
// ============================================================================
// Module   : distributor
// Brief    : Steers a tagged word stream into per-lane show-ahead FIFOs,
//            with optional broadcast to every lane.
// Revision : 1.0 - initial release
// ============================================================================
module distributor #(
    parameter int WIDTH                 = 8,
    parameter int PORTS                 = 8,
    parameter int FIFO_DEPTH            = 32,
    parameter int ALMOST_FULL_THRESHOLD = 1,
    parameter int PORTS_ADDR_WIDTH      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            d,
    input  logic [PORTS_ADDR_WIDTH-1:0] dest,
    input  logic                        bcast,
    output logic                        full,
    output logic                        almost_full,
    input  logic [0:PORTS-1]            pop,
    output logic [WIDTH*PORTS-1:0]      q,
    output logic [0:PORTS-1]            empty,
    output logic                        error
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_LEVEL = c_CNT_W'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);
    localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(FIFO_DEPTH - 1);

    logic [WIDTH-1:0] r_stage_data;
    logic             r_stage_valid;
    logic [0:PORTS-1] r_pending;
    logic             r_error;

    logic [0:PORTS-1] w_lane_full;
    logic [0:PORTS-1] w_lane_af;
    logic [0:PORTS-1] w_wr;
    logic [0:PORTS-1] w_rd;
    logic [0:PORTS-1] w_onehot;
    logic [0:PORTS-1] w_pending_left;
    logic             w_full;
    logic             w_accept;
    logic             w_dest_bad;
    logic             w_load;

    // Lane full flags come from registered counts, so a pop this cycle
    // cannot release a write until the following cycle.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_onehot[i] = (32'(dest) == i);
        end
        w_wr           = (r_stage_valid ? r_pending : '0) & ~w_lane_full;
        w_pending_left = r_pending & ~w_wr;
        w_full         = r_stage_valid && (|(r_pending & w_lane_full));
        w_accept       = push && !w_full;
        w_dest_bad     = !bcast && (32'(dest) >= PORTS);
        w_load         = w_accept && !w_dest_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_data  <= '0;
            r_stage_valid <= 1'b0;
            r_pending     <= '0;
            r_error       <= 1'b0;
        end else begin
            if (w_load) begin
                r_stage_data  <= d;
                r_pending     <= bcast ? '1 : w_onehot;
                r_stage_valid <= 1'b1;
            end else begin
                r_pending     <= w_pending_left;
                r_stage_valid <= |w_pending_left;
            end
            if ((push && w_full) || (w_accept && w_dest_bad)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign full        = w_full;
    assign almost_full = |w_lane_af;
    assign error       = r_error;

    for (genvar i = 0; i < PORTS; i++) begin : g_lane
        logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_CNT_W-1:0] r_count;

        assign w_lane_full[i] = (r_count == c_DEPTH);
        assign w_lane_af[i]   = (r_count >= c_AF_LEVEL);
        assign empty[i]       = (r_count == '0);
        assign w_rd[i]        = pop[i] && (r_count != '0);
        assign q[(PORTS-1-i)*WIDTH +: WIDTH] = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr[i]) begin
                    r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_rd[i]) begin
                    r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
                end
                case ({w_wr[i], w_rd[i]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr[i]) begin
                r_mem[r_wr_ptr] <= r_stage_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_distributor
// Brief    : Scoreboard bench for distributor (8-lane and 6-lane instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_distributor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst8, push8, bcast8, full8, af8, err8;
    logic [7:0]  d8;
    logic [2:0]  dest8;
    logic [0:7]  pop8, empty8;
    logic [63:0] q8;

    logic        rst6, push6, bcast6, full6, af6, err6;
    logic [7:0]  d6;
    logic [2:0]  dest6;
    logic [0:5]  pop6, empty6;
    logic [47:0] q6;

    logic [7:0] exp_q [8][$];

    distributor #(.WIDTH(8), .PORTS(8), .FIFO_DEPTH(32), .ALMOST_FULL_THRESHOLD(1)) u_dut8 (
        .clk(clk), .rst(rst8), .push(push8), .d(d8), .dest(dest8), .bcast(bcast8),
        .full(full8), .almost_full(af8), .pop(pop8), .q(q8), .empty(empty8), .error(err8)
    );

    distributor #(.WIDTH(8), .PORTS(6), .FIFO_DEPTH(32), .ALMOST_FULL_THRESHOLD(1)) u_dut6 (
        .clk(clk), .rst(rst6), .push(push6), .d(d6), .dest(dest6), .bcast(bcast6),
        .full(full6), .almost_full(af6), .pop(pop6), .q(q6), .empty(empty6), .error(err6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] head8(input int lane);
        return q8[(7-lane)*8 +: 8];
    endfunction

    // Expected words are queued at drive time when the push must be accepted.
    task automatic do_push(input logic [7:0] data, input int dst, input logic bc, input logic ok);
        push8  = 1'b1;
        d8     = data;
        dest8  = dst[2:0];
        bcast8 = bc;
        if (ok) begin
            for (int l = 0; l < 8; l++) begin
                if (bc || l == dst) exp_q[l].push_back(data);
            end
        end
        tick();
        push8  = 1'b0;
        bcast8 = 1'b0;
    endtask

    task automatic pop_check(input int lane);
        logic [7:0] e;
        check($sformatf("sb_nonempty_l%0d", lane), 64'(exp_q[lane].size() != 0), 64'd1);
        if (exp_q[lane].size() != 0) begin
            e = exp_q[lane].pop_front();
            check($sformatf("empty_l%0d", lane), 64'(empty8[lane]), 64'd0);
            check($sformatf("q_l%0d", lane), 64'(head8(lane)), 64'(e));
        end
        pop8[lane] = 1'b1;
        tick();
        pop8[lane] = 1'b0;
    endtask

    task automatic drain(input int lane, input int n);
        for (int k = 0; k < n; k++) pop_check(lane);
        check($sformatf("drained_l%0d", lane), 64'(empty8[lane]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst8 = 1; push8 = 0; bcast8 = 0; d8 = 0; dest8 = 0; pop8 = '0;
        rst6 = 1; push6 = 0; bcast6 = 0; d6 = 0; dest6 = 0; pop6 = '0;
        tick(); tick();
        rst8 = 0; rst6 = 0;
        check("rst_empty", 64'(empty8), 64'hFF);
        check("rst_full", 64'(full8), 64'd0);
        check("rst_af", 64'(af8), 64'd0);
        check("rst_err", 64'(err8), 64'd0);

        // Single word latency
        do_push(8'hA5, 3, 1'b0, 1'b1);
        check("lat_t2_empty3", 64'(empty8[3]), 64'd1);
        tick();
        check("lat_t3_empty", 64'(empty8), 64'hEF);
        pop_check(3);
        check("pop_empty3", 64'(empty8[3]), 64'd1);

        // Round-robin stream, no pops
        for (int i = 0; i < 64; i++) begin
            check("stream_full", 64'(full8), 64'd0);
            do_push(8'(i), i % 8, 1'b0, 1'b1);
        end
        tick(); tick();
        check("stream_af", 64'(af8), 64'd0);
        for (int l = 0; l < 8; l++) drain(l, 8);

        // Fill lane 2, overflow, drop
        for (int k = 0; k < 32; k++) begin
            do_push(8'(8'h80 + k), 2, 1'b0, 1'b1);
            if (k == 30) check("af_at30", 64'(af8), 64'd0);
            if (k == 31) check("af_at31", 64'(af8), 64'd1);
        end
        check("full_before33", 64'(full8), 64'd0);
        do_push(8'hA0, 2, 1'b0, 1'b1);
        check("full_staged", 64'(full8), 64'd1);
        check("err_before_drop", 64'(err8), 64'd0);
        do_push(8'hBB, 2, 1'b0, 1'b0);
        check("err_drop", 64'(err8), 64'd1);
        check("full_still", 64'(full8), 64'd1);
        pop_check(2);
        check("full_released", 64'(full8), 64'd0);
        tick();
        drain(2, 32);
        check("af_after_drain", 64'(af8), 64'd0);

        // Broadcast with one blocked lane
        for (int k = 0; k < 32; k++) do_push(8'(8'h40 + k), 5, 1'b0, 1'b1);
        tick();
        do_push(8'h77, 0, 1'b1, 1'b1);
        check("bc_full_t1", 64'(full8), 64'd1);
        tick();
        check("bc_full_t2", 64'(full8), 64'd1);
        check("bc_empty", 64'(empty8), 64'h00);
        for (int l = 0; l < 8; l++) begin
            if (l != 5) check($sformatf("bc_head_l%0d", l), 64'(head8(l)), 64'h77);
        end
        pop_check(5);
        check("bc_full_release", 64'(full8), 64'd0);
        tick();
        drain(5, 32);
        for (int l = 0; l < 8; l++) begin
            if (l != 5) drain(l, 1);
        end

        // Reset mid-stream
        for (int k = 0; k < 5; k++) do_push(8'(8'h10 + k), 1, 1'b0, 1'b1);
        rst8 = 1; push8 = 1; d8 = 8'hEE; dest8 = 3'd1;
        tick();
        rst8 = 0; push8 = 0;
        for (int l = 0; l < 8; l++) exp_q[l].delete();
        check("mid_rst_empty", 64'(empty8), 64'hFF);
        check("mid_rst_full", 64'(full8), 64'd0);
        check("mid_rst_af", 64'(af8), 64'd0);
        check("mid_rst_err", 64'(err8), 64'd0);
        tick();
        check("mid_rst_no_ghost", 64'(empty8), 64'hFF);
        do_push(8'h3C, 1, 1'b0, 1'b1);
        check("post_rst_t2", 64'(empty8[1]), 64'd1);
        tick();
        check("post_rst_t3", 64'(empty8), 64'hBF);
        drain(1, 1);

        // Six-lane instance: illegal destination
        push6 = 1; d6 = 8'h11; dest6 = 3'd7; bcast6 = 0;
        tick();
        push6 = 0;
        tick(); tick();
        check("p6_bad_empty", 64'(empty6), 64'h3F);
        check("p6_bad_err", 64'(err6), 64'd1);
        check("p6_bad_full", 64'(full6), 64'd0);
        rst6 = 1;
        tick();
        rst6 = 0;
        check("p6_rst_err", 64'(err6), 64'd0);
        check("p6_rst_empty", 64'(empty6), 64'h3F);
        push6 = 1; d6 = 8'h5A; dest6 = 3'd5;
        tick();
        push6 = 0;
        check("p6_lat_t2", 64'(empty6[5]), 64'd1);
        tick();
        check("p6_lat_t3", 64'(empty6), 64'h3E);
        check("p6_q5", 64'(q6[7:0]), 64'h5A);
        check("p6_af", 64'(af6), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
